// File: rtl/duty_setpoint_pkg.sv
// Shared types, default parameter values and sizing helpers for duty_setpoint.
package duty_setpoint_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRepeat
  } step_state_e;

  localparam int unsigned DefWidth          = 5;
  localparam int unsigned DefDebounceCycles = 65536;
  localparam int unsigned DefRepeatDelay    = 6000000;
  localparam int unsigned DefRepeatRate     = 1500000;
  localparam int unsigned DefDutyInit       = 0;

  // Hold timer width: ceil(log2(max(delay, rate))), never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned delay, input int unsigned rate);
    int unsigned m;
    m = (delay > rate) ? delay : rate;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-cycle debounce counter.
module btn_debounce
  import duty_setpoint_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level
);

  localparam int unsigned    CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Count cycles the synchronized input disagrees with the level; any agreement restarts.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, level and counter state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/duty_setpoint.sv
// Button-driven PWM duty setpoint with press/hold auto-repeat and a run toggle.
module duty_setpoint
  import duty_setpoint_pkg::*;
#(
  parameter int unsigned WIDTH           = DefWidth,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_RATE     = DefRepeatRate,
  parameter int unsigned DUTY_INIT       = DefDutyInit
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_run,
  output logic [WIDTH-1:0] duty,
  output logic             duty_upd,
  output logic             run
);

  localparam int unsigned       TimerW   = timer_width(REPEAT_DELAY, REPEAT_RATE);
  localparam logic [TimerW-1:0] DelayMax = TimerW'(REPEAT_DELAY - 1);
  localparam logic [TimerW-1:0] RateMax  = TimerW'(REPEAT_RATE - 1);
  localparam logic [WIDTH-1:0]  DutyMax  = '1;
  localparam logic [WIDTH-1:0]  DutyRst  = WIDTH'(DUTY_INIT);

  logic up_lvl, down_lvl, run_lvl;
  logic up_rise, down_rise, run_fall;
  logic step;

  step_state_e       state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              dir_up_q, dir_up_d;
  logic [WIDTH-1:0]  duty_q, duty_d;
  logic              duty_upd_q, duty_upd_d;
  logic              run_q, run_d;
  logic              up_prev_q, down_prev_q, run_prev_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_up),
    .level(up_lvl)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_down),
    .level(down_lvl)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_run),
    .level(run_lvl)
  );

  assign up_rise   = up_lvl & ~up_prev_q;
  assign down_rise = down_lvl & ~down_prev_q;
  assign run_fall  = ~run_lvl & run_prev_q;

  // Step FSM, saturating duty update and run toggle.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    dir_up_d = dir_up_q;
    step     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Simultaneous rises cancel each other.
        if (up_rise ^ down_rise) begin
          step     = 1'b1;
          dir_up_d = up_rise;
          timer_d  = '0;
          state_d  = StHold;
        end
      end
      StHold, StRepeat: begin
        if (!(dir_up_q ? up_lvl : down_lvl) || (up_lvl && down_lvl)) begin
          state_d = StIdle;
          timer_d = '0;
        end else if (timer_q == ((state_q == StHold) ? DelayMax : RateMax)) begin
          step    = 1'b1;
          timer_d = '0;
          state_d = StRepeat;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase

    duty_d = duty_q;
    if (step) begin
      if (dir_up_d) begin
        if (duty_q != DutyMax) duty_d = duty_q + 1'b1;
      end else begin
        if (duty_q != '0) duty_d = duty_q - 1'b1;
      end
    end
    duty_upd_d = (duty_d != duty_q);
    run_d      = run_q ^ run_fall;
  end

  // All control state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      dir_up_q    <= 1'b0;
      duty_q      <= DutyRst;
      duty_upd_q  <= 1'b0;
      run_q       <= 1'b1;
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
      run_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      dir_up_q    <= dir_up_d;
      duty_q      <= duty_d;
      duty_upd_q  <= duty_upd_d;
      run_q       <= run_d;
      up_prev_q   <= up_lvl;
      down_prev_q <= down_lvl;
      run_prev_q  <= run_lvl;
    end
  end

  assign duty     = duty_q;
  assign duty_upd = duty_upd_q;
  assign run      = run_q;

endmodule

// File: tb/tb_duty_setpoint.sv
// Directed, table-driven bench for duty_setpoint (debounce 4, delay 8, rate 2, width 5).
module tb_duty_setpoint;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_down, btn_run;
  logic [4:0] duty;
  logic       duty_upd;
  logic       run;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int upd_cnt = 0;
  int first_upd = -1;

  typedef struct {
    logic       up;
    logic       down;
    logic       rb;
    int         n;
    logic [4:0] exp_duty;
    int         exp_upd;
    logic       exp_run;
  } vec_t;

  vec_t vecs[18];

  duty_setpoint #(
    .WIDTH          (5),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_RATE    (2),
    .DUTY_INIT      (0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .btn_run (btn_run),
    .duty    (duty),
    .duty_upd(duty_upd),
    .run     (run)
  );

  always #5 clk = ~clk;

  // One clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (duty_upd === 1'b1) begin
      upd_cnt++;
      if (first_upd < 0) first_upd = cyc;
    end
  endtask

  task automatic seg(input logic u, input logic d, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      btn_up   = u;
      btn_down = d;
      btn_run  = r;
      tick();
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst_n    = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    btn_run  = 1'b0;
    for (int i = 0; i < n; i++) tick();
    rst_n = 1'b1;
  endtask

  task automatic mark();
    cyc       = 0;
    upd_cnt   = 0;
    first_upd = -1;
  endtask

  initial begin
    // Segments run back to back; tick k of the up press is the k-th edge sampling it.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 3,  5'd0, 0, 1'b1};  // idle after reset
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 6,  5'd0, 0, 1'b1};  // still within debounce latency
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1,  5'd1, 1, 1'b1};  // first step at tick 7
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 7,  5'd1, 0, 1'b1};  // hold delay
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1,  5'd2, 1, 1'b1};  // first repeat at tick 15
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 2,  5'd3, 1, 1'b1};  // repeat at tick 17
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 4,  5'd5, 2, 1'b1};  // ticks 19, 21
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 6,  5'd8, 3, 1'b1};  // release still debouncing: 23,25,27
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 5,  5'd8, 0, 1'b1};  // released, idle
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 10, 5'd8, 0, 1'b1};  // run press does nothing yet
    vecs[10] = '{1'b0, 1'b0, 1'b0, 6,  5'd8, 0, 1'b1};  // release within latency
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1,  5'd8, 0, 1'b0};  // run toggles 7 after release
    vecs[12] = '{1'b0, 1'b0, 1'b1, 10, 5'd8, 0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 6,  5'd8, 0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1,  5'd8, 0, 1'b1};  // run back to 1
    vecs[15] = '{1'b0, 1'b1, 1'b0, 6,  5'd8, 0, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1,  5'd7, 1, 1'b1};  // down step
    vecs[17] = '{1'b0, 1'b0, 1'b0, 10, 5'd7, 0, 1'b1};  // release before hold step

    do_reset(2);
    check("reset_duty", 32'(duty), 32'd0);
    check("reset_upd", 32'(duty_upd), 32'd0);
    check("reset_run", 32'(run), 32'd1);

    for (int v = 0; v < 18; v++) begin
      mark();
      seg(vecs[v].up, vecs[v].down, vecs[v].rb, vecs[v].n);
      check($sformatf("vec%0d_duty", v), 32'(duty), 32'(vecs[v].exp_duty));
      check($sformatf("vec%0d_upd", v), 32'(upd_cnt), 32'(vecs[v].exp_upd));
      check($sformatf("vec%0d_run", v), 32'(run), 32'(vecs[v].exp_run));
    end

    // Bouncy press: 1,0,1 then high to 10 cycles; stable from cycle 3 -> step at tick 9.
    do_reset(2);
    mark();
    seg(1'b1, 1'b0, 1'b0, 1);
    seg(1'b0, 1'b0, 1'b0, 1);
    seg(1'b1, 1'b0, 1'b0, 8);
    seg(1'b0, 1'b0, 1'b0, 20);
    check("bounce_upd_count", 32'(upd_cnt), 32'd1);
    check("bounce_upd_tick", 32'(first_upd), 32'd9);
    check("bounce_duty", 32'(duty), 32'd1);

    // Long hold: steps at 7, 15, 17, ..., 29 -> 9 by the raw release point.
    do_reset(2);
    mark();
    seg(1'b1, 1'b0, 1'b0, 30);
    check("hold30_duty", 32'(duty), 32'd9);
    check("hold30_upd", 32'(upd_cnt), 32'd9);
    seg(1'b1, 1'b0, 1'b0, 6);
    check("hold36_duty", 32'(duty), 32'd12);
    // Reset mid-REPEAT aborts the sequence.
    do_reset(1);
    mark();
    seg(1'b0, 1'b0, 1'b0, 10);
    check("midrst_duty", 32'(duty), 32'd0);
    check("midrst_run", 32'(run), 32'd1);
    check("midrst_upd", 32'(upd_cnt), 32'd0);

    // Saturation at the top: 31 steps land by tick 73, then no more pulses.
    do_reset(2);
    mark();
    seg(1'b1, 1'b0, 1'b0, 100);
    check("sat_climb_duty", 32'(duty), 32'd31);
    check("sat_climb_upd", 32'(upd_cnt), 32'd31);
    seg(1'b0, 1'b0, 1'b0, 10);
    mark();
    seg(1'b1, 1'b0, 1'b0, 20);
    seg(1'b0, 1'b0, 1'b0, 10);
    check("sat_top_duty", 32'(duty), 32'd31);
    check("sat_top_upd", 32'(upd_cnt), 32'd0);
    // Saturation at the bottom.
    do_reset(2);
    mark();
    seg(1'b0, 1'b1, 1'b0, 12);
    seg(1'b0, 1'b0, 1'b0, 10);
    check("sat_bot_duty", 32'(duty), 32'd0);
    check("sat_bot_upd", 32'(upd_cnt), 32'd0);

    // Simultaneous rising edges: no step.
    do_reset(2);
    mark();
    seg(1'b1, 1'b1, 1'b0, 20);
    seg(1'b0, 1'b0, 1'b0, 10);
    check("simul_duty", 32'(duty), 32'd0);
    check("simul_upd", 32'(upd_cnt), 32'd0);
    // Up held, down joins in HOLD (seen at tick 14) before the tick-15 repeat.
    mark();
    seg(1'b1, 1'b0, 1'b0, 7);
    check("both_first_step", 32'(duty), 32'd1);
    seg(1'b1, 1'b1, 1'b0, 25);
    seg(1'b0, 1'b0, 1'b0, 15);
    check("both_duty", 32'(duty), 32'd1);
    check("both_upd", 32'(upd_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/duty_setpoint.md
DUTY_SETPOINT -- requirements
Module: duty_setpoint

Interface
REQ-001 Parameter WIDTH, default 5: setpoint width in bits.
REQ-002 Parameter DEBOUNCE_CYCLES, default 65536: consecutive stable cycles needed to accept a button level change.
REQ-003 Parameter REPEAT_DELAY, default 6000000: hold cycles from the first step to the first auto-repeat step.
REQ-004 Parameter REPEAT_RATE, default 1500000: cycles between auto-repeat steps.
REQ-005 Parameter DUTY_INIT, default 0: setpoint value after reset.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 btn_up  input  1  raw asynchronous increment button, active-high.
REQ-009 btn_down  input  1  raw asynchronous decrement button, active-high.
REQ-010 btn_run  input  1  raw asynchronous start/stop button, active-high.
REQ-011 duty  output  WIDTH  registered PWM compare setpoint.
REQ-012 duty_upd  output  1  one-cycle pulse in the same cycle duty takes a new value.
REQ-013 run  output  1  registered PWM counter enable.

Function
REQ-014 Each raw button SHALL pass through a 2-flop synchronizer, then a debouncer.
REQ-015 Debounced level SHALL change on the cycle after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any return to the old level SHALL clear the count.
REQ-016 Total latency from a clean raw edge to the debounced edge SHALL be 2 + DEBOUNCE_CYCLES cycles.
REQ-017 Step FSM states SHALL be IDLE, HOLD, and REPEAT, with a hold timer of ceil(log2(max(REPEAT_DELAY, REPEAT_RATE))) bits.
REQ-018 IDLE: on a debounced rising edge of exactly one of up/down, the FSM SHALL apply one step in that direction, clear the timer, and enter HOLD.
REQ-019 HOLD: when the timer reaches REPEAT_DELAY-1, the FSM SHALL apply one step, clear the timer, and enter REPEAT; otherwise it SHALL increment the timer.
REQ-020 REPEAT: when the timer reaches REPEAT_RATE-1, the FSM SHALL apply one step and clear the timer; otherwise it SHALL increment the timer.
REQ-021 HOLD/REPEAT: release of the active button, or both up and down debounced high, SHALL return the FSM to IDLE with no step in that cycle.
REQ-022 Simultaneous up and down rising edges in IDLE SHALL cause no step and leave the FSM in IDLE.
REQ-023 A step SHALL saturate: up at 2^WIDTH-1 and down at 0 leave duty unchanged, with no wrap.
REQ-024 duty_upd SHALL be 1 only when duty actually changes; a saturated step SHALL produce no pulse.
REQ-025 Step effect on duty SHALL be visible 1 cycle after the triggering debounced edge or timer match.
REQ-026 run SHALL toggle on the cycle after a debounced falling edge (release) of btn_run, independent of the step FSM.

Reset
REQ-027 While rst_n=0 at a clk edge, the block SHALL set duty=DUTY_INIT, duty_upd=0, run=1, FSM=IDLE, timer=0.
REQ-028 Reset SHALL also set synchronizers and debounced levels to 0 and clear debounce counters.
REQ-029 A button held through reset release SHALL be accepted as a rising edge after 2 + DEBOUNCE_CYCLES cycles.
REQ-030 Reset asserted mid-HOLD/REPEAT SHALL abort the sequence with no further step.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, default parameter constants, and the timer-width function.
REQ-032 Debouncing SHALL be one sub-module, btn_debounce (synchronizer + counter, output level), instantiated three times.
REQ-033 The design SHALL contain no derived clocks and no logic clocked by button signals.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=2, WIDTH=5, DUTY_INIT=0)
REQ-034 Reset, then btn_up pulse of 10 cycles with bounce (1,0,1 in the first 3 cycles) -> exactly one duty_upd, duty 0->1, 7 cycles after the stable high begins.
REQ-035 btn_up held 30 cycles from duty=0 -> steps at t, t+8, t+10, t+12...; duty=9 at release, no step after release.
REQ-036 duty=31, btn_up held 20 cycles -> duty stays 31, duty_upd never 1; from duty=0, btn_down pressed -> duty stays 0, no pulse.
REQ-037 up and down rising in the same cycle -> no step; up held then down pressed in HOLD -> FSM IDLE, duty unchanged thereafter.
REQ-038 btn_run press 10 cycles, then release -> run 1->0 exactly 7 cycles after release; repeat -> run returns to 1.
REQ-039 rst_n low for 1 cycle during REPEAT with duty=12 -> duty=0, run=1, no duty_upd in the 10 cycles after reset while the button is released.
